// File: rtl/round_controller.sv
// Game round sequencer: ready countdown, play, serve delay, pause and game over,
// plus the round's M:SS BCD countdown driven by a frame-rate one-second tick.
module round_controller #(
   parameter int unsigned FRAMES_PER_SEC = 60,
   parameter int unsigned ROUND_MIN      = 2,
   parameter int unsigned READY_SECS     = 3,
   parameter int unsigned WIN_SCORE      = 7
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start_i,
   input  logic            pause_i,
   input  logic            point_i,
   input  logic [3:0]      score_l,
   input  logic [3:0]      score_r,
   output logic [2:0]      phase,
   output logic            play_en,
   output logic            serve_o,
   output logic            clear_scores,
   output logic [2:0][3:0] time_left,
   output logic [3:0]      ready_digit,
   output logic            game_over,
   output logic [1:0]      winner
);

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      READY      = 3'd1,
      PLAY       = 3'd2,
      SERVE_WAIT = 3'd3,
      PAUSED     = 3'd4,
      OVER       = 3'd5
   } state_t;

   localparam logic [7:0] LAST_FRAME = 8'(FRAMES_PER_SEC - 1);
   localparam logic [3:0] MIN_INIT   = 4'(ROUND_MIN);
   localparam logic [3:0] READY_INIT = 4'(READY_SECS);
   localparam logic [3:0] WIN        = 4'(WIN_SCORE);

   state_t          state;
   state_t          resume_state;
   logic [7:0]      frame_cnt;
   logic            counting;
   logic            tick;
   logic            clock_run;
   logic [2:0][3:0] time_dec;
   logic            time_zero;
   logic            score_end;
   logic [1:0]      win_code;

   assign phase = state;

   always_comb begin
      counting  = (state == READY) || (state == PLAY) || (state == SERVE_WAIT);
      tick      = counting && (frame_cnt == LAST_FRAME);
      clock_run = tick && ((state == PLAY) || (state == SERVE_WAIT));
      time_dec  = time_left;
      if (time_left[0] != 4'd0) begin
         time_dec[0] = time_left[0] - 4'd1;
      end else if (time_left[1] != 4'd0) begin
         time_dec[1] = time_left[1] - 4'd1;
         time_dec[0] = 4'd9;
      end else if (time_left[2] != 4'd0) begin
         time_dec[2] = time_left[2] - 4'd1;
         time_dec[1] = 4'd5;
         time_dec[0] = 4'd9;
      end
      time_zero = (time_dec == '0);
      score_end = (score_l >= WIN) || (score_r >= WIN);
      if (score_l > score_r)      win_code = 2'b01;
      else if (score_r > score_l) win_code = 2'b10;
      else                        win_code = 2'b11;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state        <= IDLE;
         resume_state <= PLAY;
         frame_cnt    <= '0;
         time_left    <= {MIN_INIT, 8'd0};
         ready_digit  <= '0;
         play_en      <= 1'b0;
         serve_o      <= 1'b0;
         clear_scores <= 1'b0;
         game_over    <= 1'b0;
         winner       <= '0;
      end else begin
         serve_o      <= 1'b0;
         clear_scores <= 1'b0;
         if (counting) frame_cnt <= tick ? '0 : frame_cnt + 8'd1;
         if (clock_run) time_left <= time_dec;

         // Later assignments below override the free-running defaults above.
         case (state)
            IDLE, OVER: begin
               if (start_i) begin
                  state        <= READY;
                  clear_scores <= 1'b1;
                  time_left    <= {MIN_INIT, 8'd0};
                  ready_digit  <= READY_INIT;
                  frame_cnt    <= '0;
                  game_over    <= 1'b0;
                  winner       <= '0;
                  play_en      <= 1'b0;
               end
            end
            READY: begin
               if (tick) begin
                  if (ready_digit == 4'd1) begin
                     state       <= PLAY;
                     ready_digit <= '0;
                     serve_o     <= 1'b1;
                     play_en     <= 1'b1;
                  end else begin
                     ready_digit <= ready_digit - 4'd1;
                  end
               end
            end
            PLAY, SERVE_WAIT: begin
               if (score_end || (tick && time_zero)) begin
                  state     <= OVER;
                  play_en   <= 1'b0;
                  game_over <= 1'b1;
                  winner    <= win_code;
               end else if (point_i) begin
                  state     <= SERVE_WAIT;
                  play_en   <= 1'b0;
                  frame_cnt <= '0;
               end else if ((state == SERVE_WAIT) && tick) begin
                  state   <= PLAY;
                  play_en <= 1'b1;
                  serve_o <= 1'b1;
               end else if (pause_i) begin
                  resume_state <= state;
                  state        <= PAUSED;
                  play_en      <= 1'b0;
               end
            end
            PAUSED: begin
               if (pause_i) begin
                  state   <= resume_state;
                  play_en <= (resume_state == PLAY);
               end
            end
            default: begin
               state   <= IDLE;
               play_en <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/round_controller.md
Name: round_controller

Overview:
- Sequences one game round: idle, 3-2-1 ready countdown, play, post-point serve delay, pause, game over.
- Owns the round's M:SS countdown. It loads the countdown, gates it by phase, and freezes it on pause.
- Gates the ball/paddle logic and raises serve pulses; the renderer displays its digits.
- Clocked by the frame clock; sits between the input decoders/score counters and the game logic.

Parameters:
- FRAMES_PER_SEC, 60, frames per one-second tick (legal range 2..255).
- ROUND_MIN, 2, round length in whole minutes (legal range 1..9).
- READY_SECS, 3, ready countdown length in seconds (legal range 1..9).
- WIN_SCORE, 7, score that ends the round early (legal range 1..15).

Ports:
- clk  in  1  frame clock.
- reset  in  1  synchronous, active-low (0 = reset).
- start_i  in  1  one-cycle pulse: begin a round.
- pause_i  in  1  one-cycle pulse: toggle pause.
- point_i  in  1  one-cycle pulse: a point was just scored.
- score_l  in  4  left score, unsigned.
- score_r  in  4  right score, unsigned.
- phase  out  3  IDLE=0, READY=1, PLAY=2, SERVE_WAIT=3, PAUSED=4, OVER=5.
- play_en  out  1  high only in PLAY.
- serve_o  out  1  one-cycle serve pulse.
- clear_scores  out  1  one-cycle pulse requesting a score counter clear.
- time_left  out  4x3  BCD digits [2]=M, [1]=S tens, [0]=S units.
- ready_digit  out  4  ready countdown value; 0 outside READY.
- game_over  out  1  high in OVER.
- winner  out  2  00 none, 01 left, 10 right, 11 draw; valid in OVER, 00 elsewhere.

Behaviour:
- Reset (reset==0 at a clk edge), any state:
  - phase=IDLE, time_left=ROUND_MIN:0:0, ready_digit=0.
  - serve_o, clear_scores, play_en and game_over = 0; winner=00; frame counter=0.
- Tick generation:
  - The frame counter runs 0..FRAMES_PER_SEC-1.
  - tick=1 on the cycle the counter equals FRAMES_PER_SEC-1; the counter wraps to 0 that cycle.
  - The counter advances only in READY, PLAY and SERVE_WAIT; it holds its value in PAUSED.
  - It is cleared on entry to READY and on entry to SERVE_WAIT.
- Clock BCD decrement on tick, active in PLAY and SERVE_WAIT only:
  - X:Y0 (Y>0) -> X:(Y-1)9.
  - X:00 (X>0) -> (X-1):59.
  - Otherwise units-1.
  - 0:00 holds and never wraps.
- IDLE: start_i -> READY.
  - clear_scores pulses on that same edge.
  - time_left reloads to ROUND_MIN:00; ready_digit=READY_SECS.
- READY: each tick decrements ready_digit.
  - A tick with ready_digit==1 -> PLAY, ready_digit=0, serve_o=1 for one cycle.
  - start_i, pause_i and point_i are ignored.
- PLAY / SERVE_WAIT, evaluated in priority order each cycle:
  1. End conditions -> OVER next cycle. Either:
     - score_l>=WIN_SCORE or score_r>=WIN_SCORE, or
     - a tick that makes time_left 0:00.
  2. point_i while in PLAY -> SERVE_WAIT. point_i while in SERVE_WAIT restarts the serve delay.
  3. pause_i -> PAUSED. The prior state (PLAY or SERVE_WAIT) is remembered.
  - A pause_i that coincides with a higher-priority event is dropped, not deferred.
- SERVE_WAIT exit: after exactly FRAMES_PER_SEC frames (the first tick), return to PLAY with serve_o pulsing one cycle.
- PAUSED:
  - time_left and the frame counter are frozen; play_en=0.
  - pause_i returns to the remembered state, with counter values unchanged.
  - point_i and start_i are ignored.
- OVER: game_over=1.
  - winner is latched on entry: 01 if score_l>score_r, 10 if score_r>score_l, 11 if equal.
  - Scores sampled at the entry cycle.
  - start_i behaves exactly as it does in IDLE (clear_scores pulse, reload, READY).
- start_i in READY, PLAY, SERVE_WAIT or PAUSED is ignored.
- All outputs are registered; a phase change is visible one cycle after its cause.

Test Plan:
Run with FRAMES_PER_SEC=4, ROUND_MIN=1, READY_SECS=3, WIN_SCORE=3.
1. Reset low 2 cycles -> phase=0, time_left=1:0:0, all pulses 0. Then start_i -> next cycle phase=1, ready_digit=3, clear_scores high exactly 1 cycle.
2. Countdown -> ready_digit 3,2,1 each for 4 frames. Then phase=2 with serve_o one cycle and play_en=1. After 4 more frames time_left=0:5:9.
3. Pause in PLAY at time_left=0:5:7, hold 20 frames -> time_left unchanged, play_en=0, phase=4. Second pause_i -> phase=2, and the next tick occurs after the remaining frame count.
4. point_i in PLAY -> phase=3, play_en=0. serve_o fires exactly 4 frames later, phase=2. point_i again mid-SERVE_WAIT -> the 4-frame delay restarts.
5. Drive score_l=3, score_r=1 in PLAY -> phase=5, game_over=1, winner=01. Then start_i -> phase=1, time_left=1:0:0, winner=00.
6. Let the clock expire with scores 2/2 -> time_left reaches 0:0:0 and phase=5 next cycle, winner=11, time_left held. Also: reset asserted mid-SERVE_WAIT -> phase=0 with no serve_o pulse.
